booth_seq_core: RTL and testbench

- Sequential radix-2 Booth multiplier datapath and control. It sits directly downstream of the multiplicand register and consumes its held value as the multiplicand M.
- Takes multiplier Q and a start pulse. Performs one Booth iteration per clock and returns the signed 2*WIDTH-bit product with a one-cycle done pulse.
- The control FSM that sequences the upstream register's load/hold is external; this block only consumes M.

---
 rtl/booth_pkg.sv | 26 ++
 rtl/booth_step.sv | 34 +++
 rtl/booth_seq_core.sv | 83 ++++++++
 tb/tb_booth_seq_core.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10
    } booth_op_t;

    // Radix-2 Booth recoding of the {Q[0], Q_1} bit pair.
    function automatic booth_op_t decode_op(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: conditional add/subtract of M into A,
// then arithmetic right shift of {A, Q, Q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;

    assign m_ext = {m[WIDTH-1], m};

    always_comb begin
        sum = a;
        case (decode_op(q[0], q_1))
            OP_ADD:  sum = a + m_ext;
            OP_SUB:  sum = a - m_ext;
            default: sum = a;
        endcase
        a_next   = {sum[WIDTH], sum[WIDTH:1]};
        q_next   = {sum[0], q[WIDTH-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_core.sv
// Sequential radix-2 Booth multiplier: one iteration per clock, registered
// busy/done/product, operands captured only when a start is accepted.
module booth_seq_core
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   m_in,
    input  logic [WIDTH-1:0]   q_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t           state;
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [WIDTH-1:0] m_r;
    logic [CNT_W-1:0] count;

    logic [WIDTH:0]   a_next;
    logic [WIDTH-1:0] q_next;
    logic             q_1_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a        (a),
        .q        (q),
        .q_1      (q_1),
        .m        (m_r),
        .a_next   (a_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            m_r     <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_r   <= m_in;
                        q     <= q_in;
                        a     <= '0;
                        q_1   <= 1'b0;
                        count <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a     <= a_next;
                    q     <= q_next;
                    q_1   <= q_1_next;
                    count <= count - CNT_W'(1);
                    // Final iteration: the product comes straight from the step outputs.
                    if (count == CNT_W'(1)) begin
                        product <= {a_next[WIDTH-1:0], q_next};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_core.sv
// Directed bench for booth_seq_core at WIDTH=4 with hand-computed products.
module tb_booth_seq_core;

    localparam int unsigned W = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   m_in  = '0;
    logic [W-1:0]   q_in  = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    booth_seq_core #(.WIDTH(W), .CNT_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .m_in    (m_in),
        .q_in    (q_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start at E0, scramble the operands afterwards, and follow the op to done.
    task automatic run_mul(input string tag, input logic [3:0] m, input logic [3:0] q,
                           input logic [7:0] exp);
        m_in  = m;
        q_in  = q;
        start = 1'b1;
        tick;
        start = 1'b0;
        m_in  = ~m;
        q_in  = ~q;
        check_bit({tag, "_busy_e0"}, busy, 1'b1);
        for (int unsigned i = 1; i < W; i++) begin
            tick;
            check_bit({tag, "_busy_mid"}, busy, 1'b1);
            check_bit({tag, "_done_early"}, done, 1'b0);
        end
        tick;
        check_bit({tag, "_done"}, done, 1'b1);
        check_bit({tag, "_busy_end"}, busy, 1'b0);
        check_byte({tag, "_product"}, product, exp);
        tick;
        check_bit({tag, "_done_clear"}, done, 1'b0);
        check_byte({tag, "_product_hold"}, product, exp);
    endtask

    initial begin
        int done_seen;

        #2;
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_done", done, 1'b0);
        check_byte("reset_product", product, 8'h00);
        tick;
        rst_n = 1'b1;
        tick;

        run_mul("p3x5",   4'h3, 4'h5, 8'h0F);
        run_mul("n3x5",   4'hD, 4'h5, 8'hF1);
        run_mul("p5xn3",  4'h5, 4'hD, 8'hF1);
        run_mul("0xn7",   4'h0, 4'h9, 8'h00);
        run_mul("n8xn8",  4'h8, 4'h8, 8'h40);
        run_mul("n8x7",   4'h8, 4'h7, 8'hC8);
        run_mul("p7x7",   4'h7, 4'h7, 8'h31);

        // Start while busy and operand changes mid-operation are ignored.
        m_in  = 4'h2;
        q_in  = 4'h3;
        start = 1'b1;
        tick;                       // E0
        start = 1'b0;
        m_in  = 4'h7;
        done_seen = 0;
        tick;                       // E1
        if (done) done_seen++;
        start = 1'b1;
        q_in  = 4'h7;
        tick;                       // E2 samples start while busy
        if (done) done_seen++;
        start = 1'b0;
        for (int unsigned i = 0; i < 6; i++) begin
            tick;
            if (done) done_seen++;
        end
        check_byte("ignore_product", product, 8'h06);
        check_bit("ignore_idle", busy, 1'b0);
        checks++;
        assert (done_seen == 1) else begin
            failures++;
            $error("FAIL ignore_done_count: observed=%0d expected=1", done_seen);
        end

        // Asynchronous reset between E2 and E3 aborts the op.
        m_in  = 4'h4;
        q_in  = 4'h4;
        start = 1'b1;
        tick;                       // E0
        start = 1'b0;
        tick;                       // E1
        tick;                       // E2
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_done", done, 1'b0);
        check_byte("abort_product", product, 8'h00);
        tick;
        rst_n = 1'b1;
        done_seen = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            tick;
            if (done || busy) done_seen++;
        end
        checks++;
        assert (done_seen == 0) else begin
            failures++;
            $error("FAIL abort_no_done: observed=%0d expected=0", done_seen);
        end
        run_mul("p1xn1", 4'h1, 4'hF, 8'hFF);

        // Back-to-back: restart during the done cycle.
        m_in  = 4'hE;
        q_in  = 4'h3;
        start = 1'b1;
        tick;                       // E0
        start = 1'b0;
        for (int unsigned i = 0; i < W; i++) tick;
        check_bit("b2b_first_done", done, 1'b1);
        check_byte("b2b_first_product", product, 8'hFA);
        m_in  = 4'hF;
        q_in  = 4'hF;
        start = 1'b1;
        tick;                       // E0 of second op
        start = 1'b0;
        check_bit("b2b_done_pulse_end", done, 1'b0);
        check_bit("b2b_busy", busy, 1'b1);
        check_byte("b2b_first_hold", product, 8'hFA);
        for (int unsigned i = 1; i < W; i++) begin
            tick;
            check_bit("b2b_done_early", done, 1'b0);
            check_byte("b2b_hold_mid", product, 8'hFA);
        end
        tick;
        check_bit("b2b_second_done", done, 1'b1);
        check_byte("b2b_second_product", product, 8'h01);
        tick;
        check_bit("b2b_second_clear", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
